// File: rtl/aes_round_tail.sv
// -----------------------------------------------------------------------------
// aes_round_tail
//
// Back half of one AES encryption round: ShiftRows, then MixColumns (skipped
// on the final round), then AddRoundKey. The result is computed
// combinationally from the input beat and captured in a two-entry output
// buffer (main + skid). Because of the skid entry, in_ready can come straight
// from a flop with no combinational path from out_ready, and the block still
// streams one beat per cycle.
//
// Ports:
//   clk           rising-edge clock
//   rst           synchronous active-high reset
//   in_valid      upstream has a substituted-state beat
//   in_ready      block can accept a beat this cycle (registered)
//   in_state      128-bit state, byte i at [127-8i -: 8], row i%4, column i/4
//   in_round_key  128-bit round key, same byte order
//   in_final      final round: bypass MixColumns for this beat
//   out_valid     out_state holds a valid beat
//   out_ready     downstream accepts the beat
//   out_state     ShiftRows -> MixColumns (unless final) -> XOR round key
// -----------------------------------------------------------------------------
module aes_round_tail (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic [127:0] in_round_key,
    input  logic         in_final,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state
);

    // Buffer occupancy: EMPTY (0 beats), ONE (main), FULL (main + skid).
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    state_e       state_q, state_d;
    logic         out_valid_q, out_valid_d;
    logic         in_ready_q, in_ready_d;
    logic [127:0] main_q, main_d;
    logic [127:0] skid_q, skid_d;

    logic         in_xfer;
    logic         out_xfer;
    logic [127:0] beat;

    // GF(2^8) multiply by 2, reduced by the AES polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] round_tail(input logic [127:0] st,
                                                input logic [127:0] key,
                                                input logic         fin);
        logic [7:0]   b  [16];
        logic [7:0]   sr [16];
        logic [7:0]   mc [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] res;
        for (int i = 0; i < 16; i++) begin
            b[i] = st[127-8*i -: 8];
        end
        // Row r rotates left by r: out(r,c) = in(r,(c+r) mod 4).
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr[4*c+r] = b[4*((c+r)%4)+r];
            end
        end
        // Column times [2 3 1 1; 1 2 3 1; 1 1 2 3; 3 1 1 2]; 3x = xtime(x)^x.
        for (int c = 0; c < 4; c++) begin
            a0 = sr[4*c];
            a1 = sr[4*c+1];
            a2 = sr[4*c+2];
            a3 = sr[4*c+3];
            mc[4*c]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            mc[4*c+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            mc[4*c+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            mc[4*c+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        for (int i = 0; i < 16; i++) begin
            res[127-8*i -: 8] = (fin ? sr[i] : mc[i]) ^ key[127-8*i -: 8];
        end
        return res;
    endfunction

    assign beat     = round_tail(in_state, in_round_key, in_final);
    assign in_xfer  = in_valid & in_ready_q;
    assign out_xfer = out_valid_q & out_ready;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        unique case (state_q)
            EMPTY: begin
                if (in_xfer) begin
                    main_d  = beat;
                    state_d = ONE;
                end
            end
            ONE: begin
                case ({in_xfer, out_xfer})
                    2'b10: begin
                        skid_d  = beat;
                        state_d = FULL;
                    end
                    2'b01:   state_d = EMPTY;
                    2'b11:   main_d  = beat;
                    default: ;
                endcase
            end
            FULL: begin
                // in_ready is low here, so only the drain side can move.
                if (out_xfer) begin
                    main_d  = skid_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // Handshake outputs are registered from the next state so they leave
    // flops directly.
    assign out_valid_d = (state_d != EMPTY);
    assign in_ready_d  = (state_d != FULL);

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            state_q     <= EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    // NOTE: the data registers are deliberately not reset; their contents
    // are qualified by out_valid/state, so a reset net here is pure cost.
    always_ff @(posedge clk) begin
        main_q <= main_d;
        skid_q <= skid_d;
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_state = main_q;

endmodule

// File: tb/tb_aes_round_tail.sv
// -----------------------------------------------------------------------------
// tb_aes_round_tail
//
// Directed bench for aes_round_tail. A table of {state, key, final, expected}
// records with hand-derived results drives the datapath checks; hand-written
// sequences cover backpressure, streaming and reset while full. A monitor
// compares every output transfer, in order, against a queue of expected beats.
// -----------------------------------------------------------------------------
module tb_aes_round_tail;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic [127:0] in_round_key;
    logic         in_final;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;

    aes_round_tail dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_state     (in_state),
        .in_round_key (in_round_key),
        .in_final     (in_final),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_state    (out_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] st;
        logic [127:0] key;
        logic         fin;
        logic [127:0] exp;
    } vec_t;

    localparam int NVEC = 8;
    vec_t vecs [NVEC];

    int checks = 0;
    int errors = 0;
    logic [127:0] exp_q [$];
    int out_count = 0;

    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int idx);
        in_valid     = 1'b1;
        in_state     = vecs[idx].st;
        in_round_key = vecs[idx].key;
        in_final     = vecs[idx].fin;
    endtask

    // Output monitor: sampled on the falling edge, so out_valid & out_ready
    // here means a transfer on the following rising edge.
    always @(negedge clk) begin
        if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
            out_count++;
            if (exp_q.size() == 0) begin
                check("unexpected_output", out_state, 128'hx);
            end else begin
                check("scoreboard", out_state, exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{128'hd42711aee0bf98f1b8b45de51e415230,
                    128'ha0fafe1788542cb123a339392a6c7605, 1'b0,
                    128'ha49c7ff2689f352b6b5bea43026a5049};
        vecs[1] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h0, 1'b1,
                    128'h00050a0f04090e03080d02070c01060b};
        vecs[2] = '{128'h0, 128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b0,
                    128'h2b7e151628aed2a6abf7158809cf4f3c};
        vecs[3] = '{128'hd42711aee0bf98f1b8b45de51e415230, 128'h0, 1'b1,
                    128'hd4bf5d30e0b452aeb84111f11e2798e5};
        vecs[4] = '{{4{32'hdb135345}}, 128'h0, 1'b0, {4{32'h8e4da1bc}}};
        vecs[5] = '{{4{32'hf20a225c}}, 128'h0, 1'b0, {4{32'h9fdc589d}}};
        vecs[6] = '{{16{8'h5a}}, {16{8'hff}}, 1'b0, {16{8'ha5}}};
        vecs[7] = '{128'h0, 128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b1,
                    128'h2b7e151628aed2a6abf7158809cf4f3c};

        rst          = 1'b1;
        in_valid     = 1'b0;
        in_state     = '0;
        in_round_key = '0;
        in_final     = 1'b0;
        out_ready    = 1'b0;
        tick();
        tick();
        check("reset_out_valid", {127'b0, out_valid}, 128'd0);
        check("reset_in_ready", {127'b0, in_ready}, 128'd1);
        rst = 1'b0;

        // Table vectors: one beat per iteration, out_ready held high.
        out_ready = 1'b1;
        for (int i = 0; i < NVEC; i++) begin
            drive(i);
            exp_q.push_back(vecs[i].exp);
            tick();
            in_valid = 1'b0;
            in_state = ~vecs[i].st;   // must be ignored without a transfer
            check($sformatf("vec%0d_valid", i), {127'b0, out_valid}, 128'd1);
            check($sformatf("vec%0d_data", i), out_state, vecs[i].exp);
        end
        tick();
        check("drain_empty", {127'b0, out_valid}, 128'd0);

        // Backpressure: three beats offered, two accepted.
        out_ready = 1'b0;
        drive(0);
        exp_q.push_back(vecs[0].exp);
        tick();
        check("bp_ready_after_1", {127'b0, in_ready}, 128'd1);
        drive(4);
        exp_q.push_back(vecs[4].exp);
        tick();
        check("bp_ready_after_2", {127'b0, in_ready}, 128'd0);
        drive(5);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("bp_hold_valid", {127'b0, out_valid}, 128'd1);
            check("bp_hold_data", out_state, vecs[0].exp);
            check("bp_hold_ready", {127'b0, in_ready}, 128'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp_ready_back", {127'b0, in_ready}, 128'd1);
        check("bp_second_data", out_state, vecs[4].exp);
        tick();
        check("bp_empty", {127'b0, out_valid}, 128'd0);

        // Streaming: 16 back-to-back beats.
        out_count = 0;
        for (int k = 0; k < 16; k++) begin
            check("stream_in_ready", {127'b0, in_ready}, 128'd1);
            drive(k % NVEC);
            exp_q.push_back(vecs[k % NVEC].exp);
            tick();
            check("stream_out_valid", {127'b0, out_valid}, 128'd1);
        end
        in_valid = 1'b0;
        tick();
        check("stream_count", 128'(out_count), 128'd16);
        check("stream_empty", {127'b0, out_valid}, 128'd0);

        // Reset while FULL: buffered beats must vanish.
        out_ready = 1'b0;
        drive(2);
        tick();
        drive(6);
        tick();
        check("full_before_reset", {127'b0, in_ready}, 128'd0);
        rst       = 1'b1;
        out_ready = 1'b1;
        drive(1);
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        check("post_reset_valid", {127'b0, out_valid}, 128'd0);
        check("post_reset_ready", {127'b0, in_ready}, 128'd1);
        tick();
        tick();
        check("post_reset_still_empty", {127'b0, out_valid}, 128'd0);
        drive(5);
        exp_q.push_back(vecs[5].exp);
        tick();
        in_valid = 1'b0;
        check("post_reset_beat", out_state, vecs[5].exp);
        tick();
        tick();

        check("scoreboard_drained", 128'(exp_q.size()), 128'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_round_tail.md
AES_ROUND_TAIL -- requirements
Module: aes_round_tail

Interface
REQ-001 SHALL have no parameters.
REQ-002 SHALL have one clock; reset is synchronous and active-high:
- `clk  input  1`  rising-edge clock.
- `rst  input  1`  synchronous active-high reset.

REQ-003 SHALL have the following data and handshake ports:
- `in_valid  input  1`  upstream has a beat (the 16 S-box-substituted bytes).
- `in_ready  output  1`  block accepts a beat this cycle.
- `in_state  input  128`  substituted state; byte i at [127-8i -: 8]; byte i = row i%4, column i/4.
- `in_round_key  input  128`  round key for this beat, same byte order.
- `in_final  input  1`  final round: skip MixColumns.
- `out_valid  output  1`  out_state holds a valid beat.
- `out_ready  input  1`  downstream accepts.
- `out_state  output  128`  ShiftRows -> (MixColumns unless final) -> XOR round key.

Function
REQ-004 SHALL compute ShiftRows as out(r,c) = in(r,(c+r) mod 4), using the byte mapping of REQ-003.
REQ-005 SHALL compute MixColumns per FIPS-197:
- GF(2^8) multiply-by-2 is xtime: shift left, XOR 0x1B if bit 7 was set.
- Multiply-by-3 is xtime(x) XOR x.
- Each column is multiplied by matrix [2 3 1 1; 1 2 3 1; 1 1 2 3; 3 1 1 2].

REQ-006 SHALL bypass MixColumns when in_final=1, captured per beat alongside the data.
REQ-007 SHALL XOR the 128-bit round key after ShiftRows/MixColumns; all arithmetic is byte-wise with no carries.
REQ-008 SHALL treat a transfer as occurring on a rising clk edge with valid=1 and ready=1, on either port.
REQ-009 SHALL hold the computed result in a main output register (main) backed by one skid register (skid), for a capacity of 2 beats.
REQ-010 SHALL drive in_ready directly from a flop: in_ready = NOT skid_full, with no combinational path from out_ready.
REQ-011 SHALL use a state machine with states EMPTY (0 beats), ONE (main full), and FULL (main+skid full).
REQ-012 SHALL apply these transitions:
- EMPTY + input transfer -> ONE.
- ONE + input transfer without output transfer -> FULL; the new beat goes to skid.
- ONE + output transfer without input transfer -> EMPTY.
- ONE + both -> ONE; main loads the new beat.
- FULL + output transfer -> ONE; skid moves to main.
- FULL: in_ready=0, so no input transfer occurs.

REQ-013 SHALL give a latency of 1 cycle: a beat accepted at edge N is presented on out_state with out_valid=1 after edge N.
REQ-014 SHALL sustain full throughput: one beat per cycle while out_ready=1.
REQ-015 SHALL hold out_state and out_valid stable while out_valid=1 and out_ready=0.
REQ-016 SHALL preserve beat order; no beat is dropped or duplicated.
REQ-017 SHALL ignore in_state, in_round_key, and in_final when no input transfer occurs.
REQ-018 SHALL NOT gate any data register by rst; only state/valid flops are reset.

Reset
REQ-019 SHALL, while rst=1 at an edge, force state to EMPTY, out_valid=0, and in_ready=1 after that edge.
REQ-020 SHALL treat out_state as don't-care after reset until the first out_valid.
REQ-021 SHALL discard all buffered beats on reset mid-operation, regardless of in_valid/out_ready in that cycle.
REQ-022 SHALL NOT accept a transfer on an edge where rst=1.

Verification
REQ-023 SHALL cover the following directed scenarios:
- FIPS-197 App. B round 1: in_state=d42711aee0bf98f1b8b45de51e415230, key=a0fafe1788542cb123a339392a6c7605, final=0 -> out_state=a49c7ff2689f352b6b5bea43026a5049 one cycle later.
- Final round, ShiftRows only: in_state=000102030405060708090a0b0c0d0e0f, key=0, final=1 -> out_state=00050a0f04090e03080d02070c01060b.
- Zero state, final=0, key=K -> out_state=K; MixColumns(0)=0.
- Backpressure: out_ready=0 while 3 beats are offered -> 2 accepted, in_ready=0 after the second. Then out_ready=1 -> beats emerge in order, in_ready returns to 1 one cycle after the first drain.
- Streaming: in_valid=out_ready=1 for 16 cycles -> 16 outputs on consecutive cycles; in_ready never drops.
- Reset in FULL: rst=1 for one cycle -> out_valid=0 and in_ready=1 next cycle; the pre-reset beats never appear.

REQ-024 SHALL be checked by a reference model that compares every output transfer against the expected value in order.
